// File: rtl/scr1_bpu_pkg.sv
// Shared definitions for the gshare branch predictor: XLEN/offset constants,
// FSM states, the BTB entry layout and PC field extraction helpers.
package scr1_bpu_pkg;

  localparam int XLEN         = 32;
  localparam bit SCR1_RVC_EXT = 1'b1;
  localparam int OFS          = SCR1_RVC_EXT ? 1 : 2;
  localparam int CNT_W_MAX    = 4;

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } bpu_state_e;

  // Tag is held at full XLEN width; bits above TAG_W are always zero.
  typedef struct packed {
    logic            valid;
    logic [XLEN-1:0] tag;
    logic [XLEN-1:0] target;
  } btb_entry_t;

  // Weakly-not-taken value for a cnt_w-bit counter: 2^(cnt_w-1)-1.
  function automatic logic [CNT_W_MAX-1:0] cnt_reset_val(input int cnt_w);
    return CNT_W_MAX'((1 << (cnt_w - 1)) - 1);
  endfunction

  function automatic logic [XLEN-1:0] pc_field(input logic [XLEN-1:0] pc,
                                               input int lsb, input int width);
    logic [XLEN-1:0] mask;
    mask = (width >= XLEN) ? '1 : ~({XLEN{1'b1}} << width);
    return (pc >> lsb) & mask;
  endfunction

  function automatic logic [XLEN-1:0] pc_index(input logic [XLEN-1:0] pc, input int idx_w);
    return pc_field(pc, OFS, idx_w);
  endfunction

  function automatic logic [XLEN-1:0] pc_tag(input logic [XLEN-1:0] pc,
                                             input int idx_w, input int tag_w);
    return pc_field(pc, OFS + idx_w, tag_w);
  endfunction

endpackage

// File: rtl/bpu_gshare_if.sv
// IFU <-> BPU lookup/update channel; master is the fetch unit, slave the predictor.
interface bpu_gshare_if
  import scr1_bpu_pkg::*;
#(
  parameter int GHR_W = 8
);
  localparam int GW = (GHR_W > 0) ? GHR_W : 1;

  logic            ifu2bpu_lookup_vld_i;
  logic [XLEN-1:0] ifu2bpu_pc_i;
  logic            ifu2bpu_upd_vld_i;
  logic [XLEN-1:0] ifu2bpu_upd_pc_i;
  logic            ifu2bpu_upd_taken_i;
  logic [XLEN-1:0] ifu2bpu_upd_target_i;
  logic [GW-1:0]   ifu2bpu_upd_ghr_i;

  logic            bpu2ifu_rdy_o;
  logic            bpu2ifu_pred_vld_o;
  logic            bpu2ifu_prediction_o;
  logic            bpu2ifu_btb_hit_o;
  logic [XLEN-1:0] bpu2ifu_new_pc_o;
  logic [GW-1:0]   bpu2ifu_ghr_o;

  modport master (
    output ifu2bpu_lookup_vld_i, ifu2bpu_pc_i,
    output ifu2bpu_upd_vld_i, ifu2bpu_upd_pc_i, ifu2bpu_upd_taken_i,
    output ifu2bpu_upd_target_i, ifu2bpu_upd_ghr_i,
    input  bpu2ifu_rdy_o, bpu2ifu_pred_vld_o, bpu2ifu_prediction_o,
    input  bpu2ifu_btb_hit_o, bpu2ifu_new_pc_o, bpu2ifu_ghr_o
  );

  modport slave (
    input  ifu2bpu_lookup_vld_i, ifu2bpu_pc_i,
    input  ifu2bpu_upd_vld_i, ifu2bpu_upd_pc_i, ifu2bpu_upd_taken_i,
    input  ifu2bpu_upd_target_i, ifu2bpu_upd_ghr_i,
    output bpu2ifu_rdy_o, bpu2ifu_pred_vld_o, bpu2ifu_prediction_o,
    output bpu2ifu_btb_hit_o, bpu2ifu_new_pc_o, bpu2ifu_ghr_o
  );
endinterface

// File: rtl/satcount_nbit.sv
// Combinational next-value logic for one CNT_W-bit saturating branch counter.
module satcount_nbit #(
  parameter int CNT_W = 2
) (
  input  logic [CNT_W-1:0] cnt,
  input  logic             taken,
  output logic [CNT_W-1:0] cnt_next
);

  // NOTE: cnt_next gets a default before any branch, so no path leaves it unassigned (no latch).
  always_comb begin
    cnt_next = cnt;
    if (taken && (cnt != '1)) begin
      cnt_next = cnt + 1'b1;
    end else if (!taken && (cnt != '0)) begin
      cnt_next = cnt - 1'b1;
    end
  end

endmodule

// File: rtl/bpu_gshare.sv
// Gshare direction predictor with a PC-indexed BTB; tables are swept to their
// initial state after reset, then serve 1-cycle lookups and resolved-branch updates.
module bpu_gshare
  import scr1_bpu_pkg::*;
#(
  parameter int DEPTH = 2048,
  parameter int CNT_W = 2,
  parameter int GHR_W = 8,
  parameter int TAG_W = XLEN - $clog2(DEPTH) - OFS
) (
  input logic         clk,
  input logic         rst_n,
  bpu_gshare_if.slave bus
);

  localparam int IDX_W = $clog2(DEPTH);
  localparam int GW    = (GHR_W > 0) ? GHR_W : 1;
  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(cnt_reset_val(CNT_W));

  bpu_state_e       state_q, state_d;
  logic [IDX_W-1:0] sweep_q;
  logic             rdy;
  logic [GW-1:0]    ghr_q;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_INIT;
      sweep_q <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == ST_INIT) sweep_q <= sweep_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: if (sweep_q == IDX_W'(DEPTH - 1)) state_d = ST_RUN;
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  always_comb begin
    rdy = 1'b0;
    case (state_q)
      ST_RUN:  rdy = 1'b1;
      default: rdy = 1'b0;
    endcase
  end

  logic lk_acc, upd_acc, upd_taken;
  assign lk_acc    = bus.ifu2bpu_lookup_vld_i && rdy;
  assign upd_acc   = bus.ifu2bpu_upd_vld_i && rdy;
  assign upd_taken = bus.ifu2bpu_upd_taken_i;

  // Counter index hashes PC with history; the BTB sees PC bits only.
  logic [IDX_W-1:0] lk_pc_idx, lk_idx, upd_pc_idx, upd_idx, ghr_ext, upd_ghr_ext;
  assign ghr_ext     = (GHR_W == 0) ? '0 : IDX_W'(ghr_q);
  assign upd_ghr_ext = (GHR_W == 0) ? '0 : IDX_W'(bus.ifu2bpu_upd_ghr_i);
  assign lk_pc_idx   = IDX_W'(pc_index(bus.ifu2bpu_pc_i, IDX_W));
  assign upd_pc_idx  = IDX_W'(pc_index(bus.ifu2bpu_upd_pc_i, IDX_W));
  assign lk_idx      = lk_pc_idx ^ ghr_ext;
  assign upd_idx     = upd_pc_idx ^ upd_ghr_ext;

  logic [CNT_W-1:0] cnt_mem [DEPTH];
  btb_entry_t       btb_mem [DEPTH];
  logic [CNT_W-1:0] upd_cnt_cur, upd_cnt_nxt;

  assign upd_cnt_cur = cnt_mem[upd_idx];

  satcount_nbit #(.CNT_W(CNT_W)) u_satcount (
    .cnt      (upd_cnt_cur),
    .taken    (upd_taken),
    .cnt_next (upd_cnt_nxt)
  );

  // NOTE: the tables carry no reset; the INIT sweep clears them one entry per cycle so they stay RAM-mappable.
  always_ff @(posedge clk) begin
    if (state_q == ST_INIT) begin
      cnt_mem[sweep_q] <= CNT_INIT;
      btb_mem[sweep_q] <= '0;
    end else if (upd_acc) begin
      cnt_mem[upd_idx] <= upd_cnt_nxt;
      if (upd_taken) begin
        btb_mem[upd_pc_idx] <= '{valid:  1'b1,
                                 tag:    pc_tag(bus.ifu2bpu_upd_pc_i, IDX_W, TAG_W),
                                 target: bus.ifu2bpu_upd_target_i};
      end
    end
  end

  // Registered reads see the table contents before any same-edge update.
  logic [CNT_W-1:0] rd_cnt_q;
  btb_entry_t       rd_btb_q;
  logic [XLEN-1:0]  lk_tag_q;
  logic [GW-1:0]    lk_ghr_q;
  logic             pred_vld_q;

  always_ff @(posedge clk) begin
    rd_cnt_q <= cnt_mem[lk_idx];
    rd_btb_q <= btb_mem[lk_pc_idx];
    lk_tag_q <= pc_tag(bus.ifu2bpu_pc_i, IDX_W, TAG_W);
    lk_ghr_q <= ghr_q;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pred_vld_q <= 1'b0;
      ghr_q      <= '0;
    end else begin
      pred_vld_q <= lk_acc;
      if (upd_acc && (GHR_W > 0)) ghr_q <= GW'({ghr_q, upd_taken});
    end
  end

  logic btb_hit, prediction;
  assign btb_hit    = pred_vld_q && rd_btb_q.valid && (rd_btb_q.tag == lk_tag_q);
  assign prediction = btb_hit && rd_cnt_q[CNT_W-1];

  assign bus.bpu2ifu_rdy_o        = rdy;
  assign bus.bpu2ifu_pred_vld_o   = pred_vld_q;
  assign bus.bpu2ifu_btb_hit_o    = btb_hit;
  assign bus.bpu2ifu_prediction_o = prediction;
  assign bus.bpu2ifu_new_pc_o     = prediction ? rd_btb_q.target : '0;
  assign bus.bpu2ifu_ghr_o        = pred_vld_q ? lk_ghr_q : '0;

endmodule

// File: tb/tb_bpu_gshare.sv
// Directed bench for bpu_gshare: a bimodal instance (GHR_W=0) and a gshare
// instance (GHR_W=4), both DEPTH=16, CNT_W=2, sharing clock and reset.
module tb_bpu_gshare;
  import scr1_bpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  bpu_gshare_if #(.GHR_W(0)) b0 ();
  bpu_gshare_if #(.GHR_W(4)) b1 ();

  bpu_gshare #(.DEPTH(16), .CNT_W(2), .GHR_W(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
  bpu_gshare #(.DEPTH(16), .CNT_W(2), .GHR_W(4)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1));

  // {pred_vld, btb_hit, prediction, new_pc}
  function automatic logic [34:0] obs0();
    return {b0.bpu2ifu_pred_vld_o, b0.bpu2ifu_btb_hit_o, b0.bpu2ifu_prediction_o, b0.bpu2ifu_new_pc_o};
  endfunction

  // {pred_vld, btb_hit, prediction, new_pc, ghr}
  function automatic logic [38:0] obs1();
    return {b1.bpu2ifu_pred_vld_o, b1.bpu2ifu_btb_hit_o, b1.bpu2ifu_prediction_o,
            b1.bpu2ifu_new_pc_o, b1.bpu2ifu_ghr_o};
  endfunction

  task automatic idle_all();
    b0.ifu2bpu_lookup_vld_i = 1'b0; b0.ifu2bpu_pc_i = '0;
    b0.ifu2bpu_upd_vld_i = 1'b0; b0.ifu2bpu_upd_pc_i = '0; b0.ifu2bpu_upd_taken_i = 1'b0;
    b0.ifu2bpu_upd_target_i = '0; b0.ifu2bpu_upd_ghr_i = '0;
    b1.ifu2bpu_lookup_vld_i = 1'b0; b1.ifu2bpu_pc_i = '0;
    b1.ifu2bpu_upd_vld_i = 1'b0; b1.ifu2bpu_upd_pc_i = '0; b1.ifu2bpu_upd_taken_i = 1'b0;
    b1.ifu2bpu_upd_target_i = '0; b1.ifu2bpu_upd_ghr_i = '0;
  endtask

  // Stimulus helpers: entered at a negedge, return at the following negedge.
  task automatic upd0(input logic [31:0] pc, input logic tk, input logic [31:0] tgt);
    b0.ifu2bpu_upd_vld_i = 1'b1; b0.ifu2bpu_upd_pc_i = pc;
    b0.ifu2bpu_upd_taken_i = tk; b0.ifu2bpu_upd_target_i = tgt;
    @(negedge clk);
    b0.ifu2bpu_upd_vld_i = 1'b0;
  endtask

  task automatic look0(input logic [31:0] pc);
    b0.ifu2bpu_lookup_vld_i = 1'b1; b0.ifu2bpu_pc_i = pc;
    @(negedge clk);
    b0.ifu2bpu_lookup_vld_i = 1'b0;
  endtask

  task automatic upd1(input logic [31:0] pc, input logic tk, input logic [31:0] tgt, input logic [3:0] g);
    b1.ifu2bpu_upd_vld_i = 1'b1; b1.ifu2bpu_upd_pc_i = pc;
    b1.ifu2bpu_upd_taken_i = tk; b1.ifu2bpu_upd_target_i = tgt; b1.ifu2bpu_upd_ghr_i = g;
    @(negedge clk);
    b1.ifu2bpu_upd_vld_i = 1'b0;
  endtask

  task automatic look1(input logic [31:0] pc);
    b1.ifu2bpu_lookup_vld_i = 1'b1; b1.ifu2bpu_pc_i = pc;
    @(negedge clk);
    b1.ifu2bpu_lookup_vld_i = 1'b0;
  endtask

  task automatic test_reset();
    logic [35:0] got0;
    logic [39:0] got1;
    idle_all();
    rst_n = 1'b0;
    b0.ifu2bpu_lookup_vld_i = 1'b1; b0.ifu2bpu_pc_i = 32'h100;
    repeat (3) @(negedge clk);
    got0 = {b0.bpu2ifu_rdy_o, obs0()};
    got1 = {b1.bpu2ifu_rdy_o, obs1()};
    checks++;
    if (got0 !== 36'h0) begin errors++; $display("FAIL reset_outs0: got %h exp %h", got0, 36'h0); end
    checks++;
    if (got1 !== 40'h0) begin errors++; $display("FAIL reset_outs1: got %h exp %h", got1, 40'h0); end
    b0.ifu2bpu_lookup_vld_i = 1'b0;
    rst_n = 1'b1;
    for (int c = 0; c < 16; c++) begin
      checks++;
      if ({b0.bpu2ifu_rdy_o, b1.bpu2ifu_rdy_o} !== 2'b00) begin
        errors++;
        $display("FAIL init_rdy c=%0d: got %b exp 00", c, {b0.bpu2ifu_rdy_o, b1.bpu2ifu_rdy_o});
      end
      if (c == 6) begin
        checks++;
        if (b0.bpu2ifu_pred_vld_o !== 1'b0) begin
          errors++; $display("FAIL init_lookup_vld: got %b exp 0", b0.bpu2ifu_pred_vld_o);
        end
      end
      if (c == 5) begin
        b0.ifu2bpu_lookup_vld_i = 1'b1; b0.ifu2bpu_pc_i = 32'h100;
        b1.ifu2bpu_upd_vld_i = 1'b1; b1.ifu2bpu_upd_pc_i = 32'h100;
        b1.ifu2bpu_upd_taken_i = 1'b1; b1.ifu2bpu_upd_target_i = 32'h999;
      end
      @(negedge clk);
      idle_all();
    end
    checks++;
    if ({b0.bpu2ifu_rdy_o, b1.bpu2ifu_rdy_o} !== 2'b11) begin
      errors++; $display("FAIL run_rdy: got %b exp 11", {b0.bpu2ifu_rdy_o, b1.bpu2ifu_rdy_o});
    end
  endtask

  task automatic test_init_ignored();
    look1(32'h100);
    checks++;
    if (obs1() !== {3'b100, 32'h0, 4'h0}) begin
      errors++; $display("FAIL init_upd_ignored: got %h exp %h", obs1(), {3'b100, 32'h0, 4'h0});
    end
  endtask

  task automatic test_bimodal();
    look0(32'h100);
    checks++;
    if (obs0() !== {3'b100, 32'h0}) begin
      errors++; $display("FAIL bim_cold: got %h exp %h", obs0(), {3'b100, 32'h0});
    end
    upd0(32'h100, 1'b1, 32'h200);
    upd0(32'h100, 1'b1, 32'h200);
    look0(32'h100);
    checks++;
    if (obs0() !== {3'b111, 32'h200}) begin
      errors++; $display("FAIL bim_trained: got %h exp %h", obs0(), {3'b111, 32'h200});
    end
    @(negedge clk);
    checks++;
    if (obs0() !== 35'h0) begin
      errors++; $display("FAIL bim_vld_drop: got %h exp %h", obs0(), 35'h0);
    end
  endtask

  task automatic test_saturation();
    repeat (5) upd0(32'h100, 1'b1, 32'h200);
    upd0(32'h100, 1'b0, 32'h999);
    look0(32'h100);
    checks++;
    if (obs0() !== {3'b111, 32'h200}) begin
      errors++; $display("FAIL sat_top: got %h exp %h", obs0(), {3'b111, 32'h200});
    end
    repeat (2) upd0(32'h100, 1'b0, 32'h999);
    look0(32'h100);
    checks++;
    if (obs0() !== {3'b110, 32'h0}) begin
      errors++; $display("FAIL sat_to_nt: got %h exp %h", obs0(), {3'b110, 32'h0});
    end
    upd0(32'h100, 1'b0, 32'h999);
    upd0(32'h100, 1'b1, 32'h200);
    look0(32'h100);
    checks++;
    if (obs0() !== {3'b110, 32'h0}) begin
      errors++; $display("FAIL sat_bottom: got %h exp %h", obs0(), {3'b110, 32'h0});
    end
    upd0(32'h100, 1'b1, 32'h200);
    look0(32'h100);
    checks++;
    if (obs0() !== {3'b111, 32'h200}) begin
      errors++; $display("FAIL sat_recover: got %h exp %h", obs0(), {3'b111, 32'h200});
    end
  endtask

  task automatic test_tag_alias();
    look0(32'h120);
    checks++;
    if (obs0() !== {3'b100, 32'h0}) begin
      errors++; $display("FAIL alias_tag: got %h exp %h", obs0(), {3'b100, 32'h0});
    end
    look0(32'h102);
    checks++;
    if (obs0() !== {3'b100, 32'h0}) begin
      errors++; $display("FAIL alias_idx: got %h exp %h", obs0(), {3'b100, 32'h0});
    end
  endtask

  task automatic test_back_to_back();
    b0.ifu2bpu_lookup_vld_i = 1'b1; b0.ifu2bpu_pc_i = 32'h100;
    @(negedge clk);
    checks++;
    if (obs0() !== {3'b111, 32'h200}) begin
      errors++; $display("FAIL b2b_first: got %h exp %h", obs0(), {3'b111, 32'h200});
    end
    b0.ifu2bpu_pc_i = 32'h120;
    @(negedge clk);
    b0.ifu2bpu_lookup_vld_i = 1'b0;
    checks++;
    if (obs0() !== {3'b100, 32'h0}) begin
      errors++; $display("FAIL b2b_second: got %h exp %h", obs0(), {3'b100, 32'h0});
    end
  endtask

  task automatic test_ghr();
    upd1(32'h100, 1'b1, 32'h400, 4'h0);
    upd1(32'h100, 1'b1, 32'h400, 4'h0);
    upd1(32'h100, 1'b0, 32'h999, 4'h0);
    upd1(32'h100, 1'b1, 32'h400, 4'h0);
    look1(32'h100);
    checks++;
    if (obs1() !== {3'b110, 32'h0, 4'hD}) begin
      errors++; $display("FAIL ghr_tttn: got %h exp %h", obs1(), {3'b110, 32'h0, 4'hD});
    end
  endtask

  task automatic test_same_cycle();
    b1.ifu2bpu_lookup_vld_i = 1'b1; b1.ifu2bpu_pc_i = 32'h100;
    b1.ifu2bpu_upd_vld_i = 1'b1; b1.ifu2bpu_upd_pc_i = 32'h100; b1.ifu2bpu_upd_taken_i = 1'b1;
    b1.ifu2bpu_upd_target_i = 32'h480; b1.ifu2bpu_upd_ghr_i = 4'hD;
    @(negedge clk);
    idle_all();
    checks++;
    if (obs1() !== {3'b110, 32'h0, 4'hD}) begin
      errors++; $display("FAIL rbw_old: got %h exp %h", obs1(), {3'b110, 32'h0, 4'hD});
    end
    upd1(32'h110, 1'b1, 32'h500, 4'h0);
    upd1(32'h110, 1'b1, 32'h500, 4'h0);
    upd1(32'h110, 1'b0, 32'h999, 4'h0);
    upd1(32'h110, 1'b1, 32'h500, 4'h0);
    look1(32'h100);
    checks++;
    if (obs1() !== {3'b111, 32'h480, 4'hD}) begin
      errors++; $display("FAIL rbw_written: got %h exp %h", obs1(), {3'b111, 32'h480, 4'hD});
    end
  endtask

  task automatic test_reset_mid();
    b0.ifu2bpu_lookup_vld_i = 1'b1; b0.ifu2bpu_pc_i = 32'h100;
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle_all();
    checks++;
    if ({b0.bpu2ifu_rdy_o, obs0()} !== 36'h0) begin
      errors++; $display("FAIL mid_rst_outs: got %h exp %h", {b0.bpu2ifu_rdy_o, obs0()}, 36'h0);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (b0.bpu2ifu_rdy_o !== 1'b0) begin
      errors++; $display("FAIL mid_rst_sweep: got %b exp 0", b0.bpu2ifu_rdy_o);
    end
    repeat (8) @(negedge clk);
    checks++;
    if (b0.bpu2ifu_rdy_o !== 1'b1) begin
      errors++; $display("FAIL mid_rst_rdy: got %b exp 1", b0.bpu2ifu_rdy_o);
    end
    look0(32'h100);
    checks++;
    if (obs0() !== {3'b100, 32'h0}) begin
      errors++; $display("FAIL mid_rst_btb: got %h exp %h", obs0(), {3'b100, 32'h0});
    end
    look1(32'h100);
    checks++;
    if (obs1() !== {3'b100, 32'h0, 4'h0}) begin
      errors++; $display("FAIL mid_rst_ghr: got %h exp %h", obs1(), {3'b100, 32'h0, 4'h0});
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_all();
    rst_n = 1'b0;
    @(negedge clk);
    test_reset();
    test_init_ignored();
    test_bimodal();
    test_saturation();
    test_tag_alias();
    test_back_to_back();
    test_ghr();
    test_same_cycle();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bpu_gshare.md
BPU_GSHARE -- requirements
Module: bpu_gshare

Interface
REQ-001 SHALL have parameter DEPTH, default 2048, number of predictor/BTB entries (power of two, >=16); IDX_W = log2(DEPTH).
REQ-002 SHALL have parameter CNT_W, default 2, saturating-counter width (1..4).
REQ-003 SHALL have parameter GHR_W, default 8, global-history length (0..IDX_W); 0 = bimodal mode.
REQ-004 SHALL have parameter TAG_W, default XLEN-IDX_W-OFS, BTB tag width; OFS = 1 if SCR1_RVC_EXT else 2.
REQ-005 SHALL have ports, clock and reset first: clk in 1 clock; rst_n in 1 reset.
REQ-006 SHALL have lookup ports: ifu2bpu_lookup_vld_i in 1 lookup request; ifu2bpu_pc_i in XLEN fetch PC.
REQ-007 SHALL have update ports: ifu2bpu_upd_vld_i in 1 resolved branch; ifu2bpu_upd_pc_i in XLEN branch PC; ifu2bpu_upd_taken_i in 1 outcome; ifu2bpu_upd_target_i in XLEN target; ifu2bpu_upd_ghr_i in max(GHR_W,1) history snapshot returned.
REQ-008 SHALL have outputs: bpu2ifu_rdy_o 1 tables initialised; bpu2ifu_pred_vld_o 1 result valid; bpu2ifu_prediction_o 1 predict taken; bpu2ifu_btb_hit_o 1 tag hit; bpu2ifu_new_pc_o XLEN target; bpu2ifu_ghr_o max(GHR_W,1) history used.
REQ-009 SHALL use a single clock; reset SHALL be synchronous and active-low on rst_n.

Function
REQ-010 SHALL have FSM states INIT and RUN; reset enters INIT with sweep counter 0.
REQ-011 In INIT SHALL write one entry per cycle: counter = 2^(CNT_W-1)-1 (weakly not-taken), BTB valid = 0; after entry DEPTH-1, next state RUN.
REQ-012 bpu2ifu_rdy_o SHALL be 0 in INIT, 1 in RUN; lookups and updates during INIT SHALL be ignored (pred_vld_o stays 0, no writes).
REQ-013 Lookup index SHALL be pc[IDX_W+OFS-1:OFS] XOR zero-extended GHR; with GHR_W=0, pc bits only.
REQ-014 Lookup latency SHALL be 1 cycle: pred_vld_o high the cycle after an accepted lookup, low otherwise.
REQ-015 btb_hit_o SHALL be valid && stored tag == pc[OFS+IDX_W+TAG_W-1:OFS+IDX_W]; BTB indexed by PC bits only, never GHR.
REQ-016 prediction_o SHALL be btb_hit_o && counter MSB; new_pc_o SHALL be stored target when prediction_o = 1, else 0.
REQ-017 ghr_o SHALL present the GHR value used to form that lookup's index, aligned with pred_vld_o.
REQ-018 On update, counter at index (upd_pc bits XOR upd_ghr) SHALL increment if taken, decrement if not, saturating at 2^CNT_W-1 and 0.
REQ-019 On taken update, BTB entry at upd_pc index SHALL be written: valid 1, tag, target; not-taken SHALL leave BTB unchanged.
REQ-020 On update, GHR SHALL shift left inserting upd_taken_i at bit 0 (non-speculative); GHR unchanged otherwise.
REQ-021 Lookup and update to same entry in same cycle: lookup SHALL return pre-update value (read-before-write); lookup SHALL use the pre-shift GHR.
REQ-022 Update pc and target SHALL be taken modulo 2^XLEN; no alignment check performed.

Reset
REQ-023 On rst_n = 0 at a clk edge: state INIT, sweep counter 0, GHR 0, all outputs 0 (rdy_o, pred_vld_o, prediction_o, btb_hit_o, new_pc_o, ghr_o).
REQ-024 Reset asserted mid-INIT or mid-RUN SHALL restart the full sweep; no pending lookup result SHALL be emitted after reset.

Structure
REQ-025 Counter reset constant, OFS, index/tag extraction widths and the BTB entry struct (valid, tag, target) SHALL live in shared package scr1_bpu_pkg.
REQ-026 The per-entry counter update SHALL be a sub-module satcount_nbit (CNT_W parameter, current value and taken in, next value out, combinational).
REQ-027 Tables SHALL be plain arrays without per-entry reset, to permit RAM inference.

Verification
REQ-028 Reset, DEPTH=16: rdy_o = 0 for exactly 16 cycles after rst_n rises, then 1; lookup in cycle 5 -> pred_vld_o stays 0.
REQ-029 GHR_W=0, CNT_W=2: two taken updates PC 0x100 target 0x200 -> lookup 0x100 gives prediction 1, new_pc 0x200, one cycle later.
REQ-030 Counter saturation: 5 taken then 1 not-taken at 0x100 -> prediction stays 1; 2 more not-taken -> prediction 0, btb_hit 1.
REQ-031 Tag alias: train 0x100, lookup 0x100 + DEPTH*2^OFS -> btb_hit 0, prediction 0, new_pc 0.
REQ-032 GHR_W=4: updates T,T,N,T -> ghr_o = 4'b1101; same-cycle lookup/update at one index returns old counter.
